// File: rtl/fp32_div.sv
// Sequential binary32 divider: restoring mantissa division, flush-to-zero, one-cycle done.
// Define FP32_DIV_ROUND_EN for round-to-nearest-even; otherwise the quotient is truncated.
module fp32_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient
);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_PACK, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [23:0]        mb_q, mb_d;
  logic [24:0]        rem_q, rem_d;
  logic [25:0]        qbits_q, qbits_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [31:0]        res_q, res_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [31:0]        quotient_q, quotient_d;

  logic [7:0]         ea, eb;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [25:0]        diff;
  logic               ge;
  logic [24:0]        rem_sel;
  logic [22:0]        mant_raw;
  logic               inc;
  logic [23:0]        mant_sum;
  logic signed [9:0]  exp_n, exp_fin;

  always_comb begin
    ea     = a[30:23];
    eb     = b[30:23];
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);
    a_inf  = (ea == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (eb == 8'hFF) && (b[22:0] == 23'd0);
    a_nan  = (ea == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (eb == 8'hFF) && (b[22:0] != 23'd0);

    // One restoring step: subtract the divisor when it fits, then shift.
    diff    = {1'b0, rem_q} - {2'b00, mb_q};
    ge      = ~diff[25];
    rem_sel = ge ? diff[24:0] : rem_q;

    // Normalise: a quotient below 1.0 has its leading one in bit 24.
    mant_raw = qbits_q[25] ? qbits_q[24:2] : qbits_q[23:1];
    exp_n    = qbits_q[25] ? exp_q : exp_q - 10'sd1;
`ifdef FP32_DIV_ROUND_EN
    if (qbits_q[25]) begin
      inc = qbits_q[1] & (qbits_q[0] | (|rem_q) | mant_raw[0]);
    end else begin
      inc = qbits_q[0] & ((|rem_q) | mant_raw[0]);
    end
`else
    inc = 1'b0;
`endif
    mant_sum = {1'b0, mant_raw} + {23'd0, inc};
    exp_fin  = exp_n + $signed({9'd0, mant_sum[23]});
  end

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    mb_d       = mb_q;
    rem_d      = rem_q;
    qbits_d    = qbits_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    quotient_d = quotient_q;
    case (state_q)
      S_IDLE: begin
        busy_d = start;
        if (start) begin
          sign_d = a[31] ^ b[31];
          if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            res_d   = 32'h7FC00000;
            state_d = S_DONE;
          end else if (a_inf || b_zero) begin
            res_d   = {a[31] ^ b[31], 8'hFF, 23'd0};
            state_d = S_DONE;
          end else if (a_zero || b_inf) begin
            res_d   = {a[31] ^ b[31], 31'd0};
            state_d = S_DONE;
          end else begin
            mb_d    = {1'b1, b[22:0]};
            rem_d   = {2'b01, a[22:0]};
            qbits_d = 26'd0;
            cnt_d   = 5'd25;
            exp_d   = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
            state_d = S_DIV;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DIV: begin
        qbits_d = {qbits_q[24:0], ge};
        rem_d   = rem_sel << 1;
        cnt_d   = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_d = S_PACK;
        end else begin
          state_d = S_DIV;
        end
      end
      S_PACK: begin
        if (exp_fin >= 10'sd255) begin
          res_d = {sign_q, 8'hFF, 23'd0};
        end else if (exp_fin <= 10'sd0) begin
          res_d = {sign_q, 31'd0};
        end else begin
          res_d = {sign_q, exp_fin[7:0], mant_sum[22:0]};
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        done_d     = 1'b1;
        quotient_d = res_q;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sign_q     <= 1'b0;
      exp_q      <= 10'sd0;
      mb_q       <= 24'd0;
      rem_q      <= 25'd0;
      qbits_q    <= 26'd0;
      cnt_q      <= 5'd0;
      res_q      <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      quotient_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      mb_q       <= mb_d;
      rem_q      <= rem_d;
      qbits_q    <= qbits_d;
      cnt_q      <= cnt_d;
      res_q      <= res_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      quotient_q <= quotient_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quotient_q;

endmodule

// File: tb/tb_fp32_div.sv
// Scoreboard bench for fp32_div: expected quotients queued at issue, compared at done.
module tb_fp32_div;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb[$];

  fp32_div dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .quotient(quotient)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_special(input logic [31:0] x, input logic [31:0] y);
    return (x[30:23] == 8'd0) || (x[30:23] == 8'hFF) || (y[30:23] == 8'd0) || (y[30:23] == 8'hFF);
  endfunction

  // Reference: one wide integer division instead of an iterative loop.
  function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y);
    logic s;
    int ex, ey, e;
    bit xn, yn, xi, yi, xz, yz, g, st;
    longint unsigned num, den, q, r, mant;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xn = (ex == 255) && (x[22:0] != 23'd0);
    yn = (ey == 255) && (y[22:0] != 23'd0);
    xi = (ex == 255) && (x[22:0] == 23'd0);
    yi = (ey == 255) && (y[22:0] == 23'd0);
    xz = (ex == 0);
    yz = (ey == 0);
    if (xn || yn || (xz && yz) || (xi && yi)) return 32'h7FC00000;
    if (xi || yz) return {s, 8'hFF, 23'd0};
    if (xz || yi) return {s, 31'd0};
    num = longint'({1'b1, x[22:0]}) << 25;
    den = longint'({1'b1, y[22:0]});
    q   = num / den;
    r   = num % den;
    e   = ex - ey + 127;
    if (q < (64'd1 << 25)) begin
      q = q << 1;
      e = e - 1;
    end
    mant = (q >> 2) & 64'h7FFFFF;
    g    = ((q >> 1) & 64'd1) != 64'd0;
    st   = ((q & 64'd1) != 64'd0) || (r != 64'd0);
`ifdef FP32_DIV_ROUND_EN
    if (g && (st || ((mant & 64'd1) != 64'd0))) mant = mant + 64'd1;
    if (mant == (64'd1 << 23)) begin
      mant = 64'd0;
      e    = e + 1;
    end
`else
    if (g && st) mant = mant + 64'd0;
`endif
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, e[7:0], mant[22:0]};
  endfunction

  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [31:0] exp);
    a = x;
    b = y;
    start = 1'b1;
    sb.push_back(exp);
    tick();
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(input string tag, input int lat0, input int exp_lat, input bit check_after);
    int lat;
    bit seen;
    logic [31:0] exp;
    lat = lat0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      tick();
      lat++;
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    if (seen) begin
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_busy_in_done"}, {31'd0, busy}, 32'd1);
      exp = sb.pop_front();
      chk(tag, quotient, exp);
      if (check_after) begin
        tick();
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
        chk({tag, "_hold"}, quotient, exp);
      end
    end
  endtask

  task automatic count_dones(input string tag, input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done) cnt++;
    end
    chk(tag, cnt, 0);
  endtask

  logic [31:0] ta[13];
  logic [31:0] tb_[13];
  logic [31:0] te[13];
  int          tl[13];

  initial begin
    logic [31:0] x, y;
    ta[0]  = 32'h40C00000; tb_[0]  = 32'h40000000; te[0]  = 32'h40400000; tl[0]  = 28;
`ifdef FP32_DIV_ROUND_EN
    ta[1]  = 32'h3F800000; tb_[1]  = 32'h40400000; te[1]  = 32'h3EAAAAAB; tl[1]  = 28;
`else
    ta[1]  = 32'h3F800000; tb_[1]  = 32'h40400000; te[1]  = 32'h3EAAAAAA; tl[1]  = 28;
`endif
    ta[2]  = 32'hC1700000; tb_[2]  = 32'h40400000; te[2]  = 32'hC0A00000; tl[2]  = 28;
    ta[3]  = 32'h40400000; tb_[3]  = 32'h00000000; te[3]  = 32'h7F800000; tl[3]  = 1;
    ta[4]  = 32'h00000000; tb_[4]  = 32'h00000000; te[4]  = 32'h7FC00000; tl[4]  = 1;
    ta[5]  = 32'h7F800800; tb_[5]  = 32'h40400000; te[5]  = 32'h7FC00000; tl[5]  = 1;
    ta[6]  = 32'h7F000000; tb_[6]  = 32'h3E800000; te[6]  = 32'h7F800000; tl[6]  = 28;
    ta[7]  = 32'h00800000; tb_[7]  = 32'h40000000; te[7]  = 32'h00000000; tl[7]  = 28;
    ta[8]  = 32'h7F800000; tb_[8]  = 32'hFF800000; te[8]  = 32'h7FC00000; tl[8]  = 1;
    ta[9]  = 32'hBF800000; tb_[9]  = 32'h7F800000; te[9]  = 32'h80000000; tl[9]  = 1;
    ta[10] = 32'hFF800000; tb_[10] = 32'h40000000; te[10] = 32'hFF800000; tl[10] = 1;
    ta[11] = 32'h80000000; tb_[11] = 32'hC0000000; te[11] = 32'h00000000; tl[11] = 1;
    ta[12] = 32'h00400000; tb_[12] = 32'h3F800000; te[12] = 32'h00000000; tl[12] = 1;

    tick();
    tick();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_quotient", quotient, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      issue(ta[i], tb_[i], te[i]);
      wait_done($sformatf("vec%0d", i), 0, tl[i], 1'b1);
    end

    // Back-to-back issue on the edge where done drops.
    for (int i = 0; i < 24; i++) begin
      if (i % 4 == 3) begin
        x = $urandom;
        y = $urandom;
      end else begin
        x = {1'($urandom_range(1, 0)), 8'($urandom_range(154, 100)), 23'($urandom)};
        y = {1'($urandom_range(1, 0)), 8'($urandom_range(154, 100)), 23'($urandom)};
      end
      issue(x, y, model(x, y));
      wait_done($sformatf("rnd%0d", i), 0, is_special(x, y) ? 1 : 28, i == 23);
    end

    // A second start mid-operation must be ignored.
    issue(32'h40C00000, 32'h40000000, 32'h40400000);
    for (int i = 0; i < 4; i++) tick();
    a = 32'h3F800000;
    b = 32'h00000000;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ignored_start", 5, 28, 1'b1);
    count_dones("ignored_no_extra_done", 30);

    // Reset mid-operation aborts without a done.
    issue(32'h3F800000, 32'h40400000, model(32'h3F800000, 32'h40400000));
    for (int i = 0; i < 9; i++) tick();
    rst_n = 1'b0;
    tick();
    sb.delete();
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_quotient", quotient, 32'd0);
    rst_n = 1'b1;
    count_dones("abort_no_done", 35);

    // Start coinciding with reset is dropped.
    rst_n = 1'b0;
    a = 32'h40C00000;
    b = 32'h40000000;
    start = 1'b1;
    tick();
    start = 1'b0;
    rst_n = 1'b1;
    chk("reset_start_busy", {31'd0, busy}, 32'd0);
    count_dones("reset_start_no_done", 32);

    issue(32'hC1700000, 32'h40400000, 32'hC0A00000);
    wait_done("after_reset", 0, 28, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
